sim_bram_pipe: RTL and testbench

SIM_BRAM_PIPE -- requirements
Module: sim_bram_pipe

---
 rtl/sim_bram_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_sim_bram_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sim_bram_pipe.sv
// -----------------------------------------------------------------------------
// sim_bram_pipe
//   Simulation model of a simple dual-port block RAM. It has one write port
//   with byte enables and one pipelined read port. The read latency is 1 or 2
//   cycles. The read-during-write behaviour on the same address is selectable.
//
// Optional feature, controlled by the macro SIM_BRAM_PIPE_CLEAR_EN:
//   When the macro is defined, reset starts a clear sweep. The sweep writes
//   zero to one word per cycle, starting at address 0. The block reports busy
//   until the word at DEPTH-1 has been cleared.
//   When the macro is undefined, memory contents are left uninitialised.
//   In that case busy drops at the first rising edge after reset release.
//
// Parameters
//   DATA_WIDTH : word width in bits (multiple of 8)
//   ADDR_WIDTH : word address width, DEPTH = 2**ADDR_WIDTH
//   RD_LAT     : read latency in cycles (1 or 2)
//   RDW_MODE   : same-address read-during-write, 0 = old data, 1 = new data
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst    : asynchronous active-high reset
//   wen    : write request
//   wbe    : byte write enables, bit i gates wdata[8i+7:8i]
//   waddr  : write word address
//   wdata  : write data
//   ren    : read request
//   raddr  : read word address
//   rdata  : registered read data, holds its value between reads
//   rvalid : one-cycle pulse that qualifies rdata
//   busy   : high while requests are being discarded
// -----------------------------------------------------------------------------
module sim_bram_pipe #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 15,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wen,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    ren,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    busy
);

    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH/8;

    // NOTE: the storage array has no reset. A real block RAM cannot be cleared
    // in one cycle, so only the pipeline registers take rst.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;

    // -------------------------------------------------------------------------
    // Busy / clear control
    // -------------------------------------------------------------------------
`ifdef SIM_BRAM_PIPE_CLEAR_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;

    // NOTE: registers use non-blocking assignments. All flops then sample
    // values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    // NOTE: every output of this block gets a default value before the case
    // statement. No path can leave a value unassigned, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        clear_we     = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clear_we     = 1'b1;
                clear_addr_d = clear_addr_q + ADDR_WIDTH'(1);
                // The last word is cleared at this edge, so go idle after it.
                if (clear_addr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    assign clear_addr = clear_addr_q;
    assign busy       = (state_q == ST_CLEAR);
`else
    logic busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b1;
        end else begin
            busy_q <= 1'b0;
        end
    end

    assign clear_we   = 1'b0;
    assign clear_addr = '0;
    assign busy       = busy_q;
`endif

    // -------------------------------------------------------------------------
    // Request qualification and word merging
    // -------------------------------------------------------------------------
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_acc = wen & ~busy;
    assign rd_acc = ren & ~busy;

    // This is the full word after the write. Disabled bytes keep their old
    // contents, so a write with wbe = 0 rewrites the word unchanged.
    always_comb begin
        wr_word = mem_q[waddr];
        for (int i = 0; i < NBYTES; i++) begin
            if (wbe[i]) begin
                wr_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // In write-first mode, a read of the address being written this cycle
    // returns the merged word instead of the stored one.
    always_comb begin
        rd_word = mem_q[raddr];
        if ((RDW_MODE == 1) && wr_acc && (waddr == raddr)) begin
            rd_word = wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[clear_addr] <= '0;
        end else if (wr_acc) begin
            mem_q[waddr] <= wr_word;
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) begin
                        rdata_q <= rd_word;
                    end
                end
            end
        end else if (RD_LAT == 2) begin : g_lat2
            logic                  s1_valid_q;
            logic [DATA_WIDTH-1:0] s1_data_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    rvalid_q   <= 1'b0;
                    rdata_q    <= '0;
                end else begin
                    s1_valid_q <= rd_acc;
                    if (rd_acc) begin
                        s1_data_q <= rd_word;
                    end
                    rvalid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        rdata_q <= s1_data_q;
                    end
                end
            end
        end else begin : g_bad_lat
            $fatal(1, "sim_bram_pipe: RD_LAT must be 1 or 2");
        end
    endgenerate

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_sim_bram_pipe.sv
// -----------------------------------------------------------------------------
// tb_sim_bram_pipe
//   This bench drives two instances of sim_bram_pipe with the same stimulus:
//     instance 0: RD_LAT = 1, read-first
//     instance 1: RD_LAT = 2, write-first
//   A word-array reference model predicts each read result and the cycle on
//   which it must appear. The driver pushes these predictions into one queue
//   per instance. A negedge monitor pops the queues and compares them against
//   the DUT outputs.
//   Define SIM_BRAM_PIPE_CLEAR_EN to test the reset clear sweep.
// -----------------------------------------------------------------------------
module tb_sim_bram_pipe;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int NB    = DW/8;
    localparam int DEPTH = 2**AW;
`ifdef SIM_BRAM_PIPE_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    // Number of rising edges after reset release for which busy stays high.
    localparam int BUSY_AFTER_RST = CLEAR_EN ? DEPTH : 1;
    localparam int LAT_A = 1;
    localparam int LAT_B = 2;
    localparam logic [DW-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wen = 1'b0;
    logic [NB-1:0] wbe = '0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ren = 1'b0;
    logic [AW-1:0] raddr = '0;

    logic [DW-1:0] rdata_m  [2];
    logic          rvalid_m [2];
    logic          busy_m   [2];

    sim_bram_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(LAT_A), .RDW_MODE(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata_m[0]), .rvalid(rvalid_m[0]),
        .busy(busy_m[0])
    );

    sim_bram_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(LAT_B), .RDW_MODE(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata_m[1]), .rvalid(rvalid_m[1]),
        .busy(busy_m[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            busy_left = BUSY_AFTER_RST;
    logic [DW-1:0] model_mem [DEPTH];
    exp_t          exp_q [2][$];
    logic [DW-1:0] last_data [2];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Expected busy window: a countdown of edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) busy_left = BUSY_AFTER_RST;
        else if (busy_left > 0) busy_left--;
    end

    // Monitor: compare each instance against its prediction queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("busy[%0d]", d), {63'd0, busy_m[d]},
                  {63'd0, (rst || busy_left > 0)});
            if (rst) begin
                check($sformatf("rst_rvalid[%0d]", d), {63'd0, rvalid_m[d]}, '0);
                check($sformatf("rst_rdata[%0d]", d), rdata_m[d], '0);
                last_data[d] = '0;
            end else if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
                check($sformatf("rvalid_due[%0d]", d), {63'd0, rvalid_m[d]}, 64'd1);
                check($sformatf("rdata[%0d]", d), rdata_m[d], exp_q[d][0].data);
                last_data[d] = exp_q[d][0].data;
                void'(exp_q[d].pop_front());
            end else begin
                check($sformatf("no_rvalid[%0d]", d), {63'd0, rvalid_m[d]}, '0);
                check($sformatf("rdata_hold[%0d]", d), rdata_m[d], last_data[d]);
            end
        end
    end

    // Drive one cycle of requests. If the block is expected to accept them,
    // update the model and queue the expected read results.
    task automatic step(input logic w, input logic [NB-1:0] be, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra);
        logic [DW-1:0] mask;
        logic [DW-1:0] merged;
        logic [DW-1:0] old;
        exp_t          e;
        wen = w; wbe = be; waddr = wa; wdata = wd; ren = r; raddr = ra;
        if (!rst && busy_left == 0) begin
            for (int i = 0; i < NB; i++) mask[8*i +: 8] = {8{be[i]}};
            merged = (model_mem[wa] & ~mask) | (wd & mask);
            if (r) begin
                old    = model_mem[ra];
                e.data = old;
                e.due  = cyc + LAT_A;
                exp_q[0].push_back(e);
                e.data = (w && wa == ra) ? merged : old;
                e.due  = cyc + LAT_B;
                exp_q[1].push_back(e);
            end
            if (w) model_mem[wa] = merged;
        end
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; wbe = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 4*DEPTH && busy_left > 0; n++) idle(1);
    endtask

    // Assert reset, which drops any reads in flight. Issue requests while
    // reset is high; they must be ignored. Then release reset.
    task automatic do_reset();
        rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        if (CLEAR_EN) for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
        step(1'b1, '1, 4'd3, JUNK, 1'b1, 4'd3);
        idle(1);
        rst = 1'b0;
    endtask

    initial begin
        last_data[0] = '0;
        last_data[1] = '0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = CLEAR_EN ? '0 : 'x;

        // Reset, then send requests while busy; they must be discarded.
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, '1, 4'd3, JUNK, 1'b1, 4'd3);
        rst = 1'b0;
        step(1'b1, '1, 4'd4, JUNK, 1'b1, 4'd4);
        wait_ready();

        // After a clear sweep, every word must read zero.
        if (CLEAR_EN) for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a));

        // Give every word a defined value.
        for (int a = 0; a < DEPTH; a++)
            step(1'b1, '1, AW'(a), {$urandom(), $urandom()}, 1'b0, '0);

        // Write a full pattern, then read it back on the next cycle.
        step(1'b1, '1, 4'd3, {8{8'hA5}}, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd3);

        // Write only byte 0.
        step(1'b1, '1, 4'd7, {8{8'h11}}, 1'b0, '0);
        step(1'b1, 8'h01, 4'd7, '1, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd7);

        // Read and write the same address in one cycle, full and partial.
        step(1'b1, '1, 4'd5, 64'h1, 1'b0, '0);
        step(1'b1, '1, 4'd5, 64'h2, 1'b1, 4'd5);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5);
        step(1'b1, 8'hF0, 4'd6, {$urandom(), $urandom()}, 1'b1, 4'd6);

        // A write with all byte enables off leaves the word unchanged.
        step(1'b1, '0, 4'd9, '1, 1'b1, 4'd9);
        step(1'b0, '0, '0, '0, 1'b1, 4'd9);

        // Back-to-back reads, each with a write to another address.
        step(1'b1, '1, 4'd10, {$urandom(), $urandom()}, 1'b1, 4'd0);
        step(1'b1, '1, 4'd11, {$urandom(), $urandom()}, 1'b1, 4'd1);
        step(1'b1, '1, 4'd12, {$urandom(), $urandom()}, 1'b1, 4'd2);
        step(1'b0, '0, '0, '0, 1'b1, 4'd10);
        idle(3);

        // Reset with a read in flight. Memory must survive the reset, unless
        // the clear sweep is enabled.
        step(1'b0, '0, '0, '0, 1'b1, 4'd1);
        do_reset();
        wait_ready();
        step(1'b0, '0, '0, '0, 1'b1, 4'd3);
        step(1'b0, '0, '0, '0, 1'b1, 4'd4);

        // Reset at clear address 8 restarts the full clear sweep.
        if (CLEAR_EN) begin
            for (int a = 0; a < DEPTH; a++) step(1'b1, '1, AW'(a), JUNK, 1'b0, '0);
            do_reset();
            idle(8);
            do_reset();
            wait_ready();
            for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a));
        end

        // Random traffic.
        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 1)), NB'($urandom_range(0, 255)),
                 AW'($urandom_range(0, DEPTH-1)), {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)));

        idle(4);
        check("drain[0]", 64'(exp_q[0].size()), '0);
        check("drain[1]", 64'(exp_q[1].size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
